// File: rtl/uart_tx.sv
// uart_tx: single-buffered serial transmitter.
// Line idles at 0; a frame is start=1, DATA_BITS data bits LSB first,
// optional even-parity bit, stop=0. Every line bit lasts CLKS_PER_BIT clocks.
// A one-entry holding buffer lets the next byte be accepted while a frame
// is on the line, so consecutive frames run back to back without idle cycles.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 signal,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state_reg;
  logic                 buf_full_reg;
  logic [DATA_BITS-1:0] buf_data_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_reg;
  logic [7:0]           clk_cnt_reg;
  logic [2:0]           bit_cnt_reg;
  logic                 signal_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic period_end;
  logic accept;
  logic load;

  // End of the current bit period; accept only into an empty buffer and
  // drain the buffer only when it is full, so both never share an edge.
  assign period_end = (clk_cnt_reg == LAST_CLK);
  assign accept     = tx_valid & ~buf_full_reg;
  assign load       = buf_full_reg &
                      ((state_reg == IDLE) || ((state_reg == STOP) && period_end));

  assign tx_ready = ~buf_full_reg;
  assign signal   = signal_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  // Holding buffer: filled on accept, emptied when a frame starts from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_reg <= 1'b0;
      buf_data_reg <= '0;
    end else if (accept) begin
      buf_full_reg <= 1'b1;
      buf_data_reg <= tx_data;
    end else if (load) begin
      buf_full_reg <= 1'b0;
    end
  end

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      clk_cnt_reg <= 8'd0;
      bit_cnt_reg <= 3'd0;
      signal_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (buf_full_reg) begin
            state_reg   <= START;
            shift_reg   <= buf_data_reg;
            parity_reg  <= ^buf_data_reg;
            clk_cnt_reg <= 8'd0;
            bit_cnt_reg <= 3'd0;
            signal_reg  <= 1'b1;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
          end
        end

        START: begin
          if (period_end) begin
            state_reg   <= DATA;
            clk_cnt_reg <= 8'd0;
            bit_cnt_reg <= 3'd0;
            signal_reg  <= shift_reg[0];
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 8'd1;
          end
        end

        DATA: begin
          if (period_end) begin
            clk_cnt_reg <= 8'd0;
            if (bit_cnt_reg == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state_reg  <= PARITY;
                signal_reg <= parity_reg;
              end else begin
                state_reg  <= STOP;
                signal_reg <= 1'b0;
                done_reg   <= (LAST_CLK == 8'd0);
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              shift_reg   <= shift_reg >> 1;
              signal_reg  <= shift_reg[1];
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 8'd1;
          end
        end

        PARITY: begin
          if (period_end) begin
            state_reg   <= STOP;
            clk_cnt_reg <= 8'd0;
            signal_reg  <= 1'b0;
            done_reg    <= (LAST_CLK == 8'd0);
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 8'd1;
          end
        end

        STOP: begin
          if (period_end) begin
            clk_cnt_reg <= 8'd0;
            bit_cnt_reg <= 3'd0;
            done_reg    <= 1'b0;
            if (buf_full_reg) begin
              // Next frame starts straight after the stop bit.
              state_reg  <= START;
              shift_reg  <= buf_data_reg;
              parity_reg <= ^buf_data_reg;
              signal_reg <= 1'b1;
              busy_reg   <= 1'b1;
            end else begin
              state_reg  <= IDLE;
              signal_reg <= 1'b0;
              busy_reg   <= 1'b0;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 8'd1;
            done_reg    <= ((clk_cnt_reg + 8'd1) == LAST_CLK);
          end
        end

        default: begin
          state_reg   <= IDLE;
          clk_cnt_reg <= 8'd0;
          bit_cnt_reg <= 3'd0;
          signal_reg  <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames on a CLKS_PER_BIT=1 instance and a
// CLKS_PER_BIT=4 instance, compared cycle by cycle against frames built
// from the frame-format rules (bit list expanded by the bit period).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v = 1'b0;
  logic [7:0] d = 8'h00;
  logic       sel = 1'b0;

  logic tx_valid_a, tx_ready_a, signal_a, busy_a, done_a;
  logic tx_valid_b, tx_ready_b, signal_b, busy_b, done_b;
  logic ready_o, signal_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  logic exp_sig_q[$];
  logic exp_done_q[$];

  always #5 clk = ~clk;

  assign tx_valid_a = v & ~sel;
  assign tx_valid_b = v & sel;

  assign ready_o  = sel ? tx_ready_b : tx_ready_a;
  assign signal_o = sel ? signal_b   : signal_a;
  assign busy_o   = sel ? busy_b     : busy_a;
  assign done_o   = sel ? done_b     : done_a;

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_a), .tx_data(d),
    .tx_ready(tx_ready_a), .signal(signal_a), .busy(busy_a), .done(done_a)
  );

  uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut4 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_b), .tx_data(d),
    .tx_ready(tx_ready_b), .signal(signal_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits of one frame: start 1, data LSB first, even parity, stop 0.
  task automatic build(input logic [7:0] data, input int cpb);
    logic bits[$];
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    bits.push_back(^data);
    bits.push_back(1'b0);
    foreach (bits[i]) begin
      for (int c = 0; c < cpb; c++) begin
        exp_sig_q.push_back(bits[i]);
        exp_done_q.push_back((i == bits.size() - 1) && (c == cpb - 1));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_one(input string tag);
    logic es, ed;
    es = exp_sig_q.pop_front();
    ed = exp_done_q.pop_front();
    chk({tag, "_signal"}, signal_o, es);
    chk({tag, "_done"}, done_o, ed);
    chk({tag, "_busy"}, busy_o, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_signal"}, signal_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_ready"}, ready_o, 1'b1);
  endtask

  // Offer one byte from idle, then follow its whole frame.
  task automatic send_frame(input logic [7:0] data, input int cpb);
    int n;
    sel = (cpb == 4);
    d = data;
    v = 1'b1;
    chk("pre_accept_ready", ready_o, 1'b1);
    step();
    v = 1'b0;
    chk("post_accept_ready", ready_o, 1'b0);
    chk("post_accept_busy", busy_o, 1'b0);
    chk("post_accept_signal", signal_o, 1'b0);
    build(data, cpb);
    n = exp_sig_q.size();
    for (int k = 0; k < n; k++) begin
      step();
      check_one("frame");
    end
    step();
    check_idle("after_frame");
    $display("frame data=%02h cpb=%0d cycles=%0d", data, cpb, n);
  endtask

  initial begin
    // Reset asserted before the first clock edge.
    #1 reset = 1'b1;
    #1;
    sel = 1'b0;
    check_idle("reset_pre_clk");
    sel = 1'b1;
    check_idle("reset_pre_clk4");
    sel = 1'b0;
    step();
    check_idle("reset_c1");
    step();
    check_idle("reset_c2");
    reset = 1'b0;

    // First edge after release accepts; directed frames.
    send_frame(8'hA5, 1);
    send_frame(8'h07, 1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1);

    // Back-to-back: 0x01 then 0x80 with tx_valid held.
    sel = 1'b0;
    d = 8'h01;
    v = 1'b1;
    step();
    d = 8'h80;
    chk("b2b_first_accept", ready_o, 1'b0);
    build(8'h01, 1);
    build(8'h80, 1);
    for (int k = 0; k < 22; k++) begin
      step();
      if (k == 0) chk("b2b_buffer_drained", ready_o, 1'b1);
      if (k == 1) begin
        chk("b2b_second_accept", ready_o, 1'b0);
        v = 1'b0;
      end
      check_one("b2b");
    end
    step();
    check_idle("b2b_end");
    $display("frame data=01,80 back-to-back cycles=22");

    // Reset during data bit 3 of 0xFF with 0x33 buffered.
    d = 8'hFF;
    v = 1'b1;
    step();
    d = 8'h33;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) begin
        chk("rst_second_accept", ready_o, 1'b0);
        v = 1'b0;
      end
    end
    chk("rst_bit3_signal", signal_o, 1'b1);
    chk("rst_bit3_busy", busy_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_idle("rst_async");
    step();
    check_idle("rst_held");
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      check_idle("rst_after");
    end
    $display("frame data=ff aborted by reset, buffered 33 discarded");

    // CLKS_PER_BIT=4 instance.
    send_frame(8'h3C, 4);
    send_frame(8'($urandom_range(0, 255)), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the number of payload bits per frame (legal 5..8).
REQ-002 Parameter CLKS_PER_BIT, default 1, SHALL set the clock cycles each line bit is held (legal 1..255).
REQ-003 Parameter PARITY_EN, default 1, SHALL insert an even-parity bit after the data bits when 1 and omit it when 0.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tx_valid  input  1  a byte is offered on tx_data.
REQ-007 tx_data  input  DATA_BITS  payload to send, LSB first.
REQ-008 tx_ready  output  1  the holding buffer is empty and the block can accept a byte.
REQ-009 signal  output  1  serial line; idle level 0.
REQ-010 busy  output  1  a frame is on the line.
REQ-011 done  output  1  one-cycle pulse in the final cycle of each stop bit.

Function
REQ-012 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_data is captured into a one-entry holding buffer.
REQ-013 When tx_ready=0, tx_valid and tx_data SHALL be ignored and the buffer content SHALL be kept unchanged.
REQ-014 Frame format SHALL be: start bit = 1, DATA_BITS data bits LSB first, optional parity bit = XOR of data bits, one stop bit = 0.
REQ-015 Each line bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by an internal bit-period counter.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY is skipped when PARITY_EN=0.
REQ-017 IDLE -> START SHALL occur on the edge after the buffer becomes full; the buffer moves into the shift register and empties on that edge.
REQ-018 START -> DATA, DATA -> PARITY/STOP (after the last data bit), and PARITY -> STOP SHALL each occur at the end of a bit period.
REQ-019 STOP -> START SHALL occur without an idle cycle if the buffer is full at the end of the stop bit; otherwise STOP -> IDLE.
REQ-020 signal SHALL be driven from a register, never combinationally from the inputs, so it is glitch-free.
REQ-021 Latency: first cycle of the start bit SHALL be one clock after acceptance when in IDLE with the buffer empty.
REQ-022 Frame length SHALL be (2 + DATA_BITS + PARITY_EN) × CLKS_PER_BIT cycles.
REQ-023 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-024 tx_ready SHALL equal NOT(buffer full), so a second byte can be accepted while a frame is in flight.
REQ-025 Simultaneous accept and buffer-to-shifter transfer on the same edge SHALL be impossible by construction (accept requires the buffer to be empty).
REQ-026 done SHALL be asserted only in the last cycle of STOP and SHALL be 0 at all other times.

Reset
REQ-027 While reset=1: signal=0, busy=0, done=0, tx_ready=1, the FSM in IDLE, the buffer empty, and all counters at 0, taking effect immediately without waiting for clk.
REQ-028 Reset mid-frame SHALL abort the frame and discard buffered data; no partial frame resumes after reset releases.
REQ-029 On the first edge after reset deasserts, the block SHALL accept a byte if tx_valid=1.

Verification (DATA_BITS=8, PARITY_EN=1, CLKS_PER_BIT=1 unless stated)
REQ-030 Reset held 2 cycles -> signal=0, busy=0, tx_ready=1, done=0 throughout, including before the first clock edge.
REQ-031 Send 0xA5 -> line bits 1,1,0,1,0,0,1,0,1,0,0 on 11 consecutive cycles starting one cycle after accept; done high in cycle 11 only.
REQ-032 Send 0x07 -> parity bit = 1 (frame 1,1,1,1,0,0,0,0,0,1,0).
REQ-033 Offer 0x01 and then 0x80 with tx_valid held -> second byte accepted during the first frame; its start bit appears on the cycle directly after the first stop bit; 22 busy cycles with no gap.
REQ-034 Assert reset during data bit 3 of 0xFF with a second byte buffered -> signal falls to 0 asynchronously; after release the line stays 0 with busy=0 and no frame from either byte.
REQ-035 CLKS_PER_BIT=4, send 0x3C -> each bit held 4 cycles; frame is 44 cycles; done high for one cycle only.
